// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and small op-classification helpers used by the unit and its sign stage.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam logic [5:0] LAST_ITER = 6'd31;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    function automatic logic is_iterative(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_sign.sv
// Combinational sign handling: operand magnitudes on the way in and
// sign correction (plus the divide-by-zero result) on the way out.
module muldiv_sign
    import muldiv_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] mag_a,
    output logic [31:0] mag_b,
    output logic        neg_a,
    output logic        neg_b,
    input  logic [2:0]  op_q,
    input  logic        neg_a_q,
    input  logic        neg_b_q,
    input  logic        div_zero_q,
    input  logic [31:0] a_q,
    input  logic [63:0] raw,
    output logic [63:0] result
);

    logic [31:0] raw_quo;
    logic [31:0] raw_rem;

    always_comb begin
        neg_a = is_signed_op(op) & a[31];
        neg_b = is_signed_op(op) & b[31];
        mag_a = neg_a ? (32'd0 - a) : a;
        mag_b = neg_b ? (32'd0 - b) : b;
    end

    // For divides the raw word is {remainder, quotient}; for multiplies it is the product.
    always_comb begin
        raw_quo = raw[31:0];
        raw_rem = raw[63:32];
        result  = raw;
        case (op_q)
            OP_MULT: begin
                if (neg_a_q ^ neg_b_q)
                    result = 64'd0 - raw;
            end
            OP_DIV, OP_DIVU: begin
                if (div_zero_q) begin
                    result = {a_q, 32'hFFFF_FFFF};
                end else begin
                    result[31:0]  = (neg_a_q ^ neg_b_q) ? (32'd0 - raw_quo) : raw_quo;
                    result[63:32] = neg_a_q ? (32'd0 - raw_rem) : raw_rem;
                end
            end
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: 32-cycle shift-add multiply
// and restoring divide, plus direct MTHI/MTLO loads while idle.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    state_t      state;
    state_t      state_next;
    logic [5:0]  count;
    logic [2:0]  op_q;
    logic        neg_a_q;
    logic        neg_b_q;
    logic        div_zero_q;
    logic [31:0] a_q;
    logic [31:0] opnd_q;
    logic [31:0] work_hi;
    logic [31:0] work_lo;
    logic        wb_pending;

    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        neg_a;
    logic        neg_b;
    logic [63:0] result;

    logic        idle;
    logic        accept_iter;
    logic        accept_mt;

    logic [32:0] add_sum;
    logic [32:0] trial;
    logic [32:0] diff;
    logic        fits;
    logic [31:0] next_hi;
    logic [31:0] next_lo;

    muldiv_sign u_sign (
        .op         (op),
        .a          (A),
        .b          (B),
        .mag_a      (mag_a),
        .mag_b      (mag_b),
        .neg_a      (neg_a),
        .neg_b      (neg_b),
        .op_q       (op_q),
        .neg_a_q    (neg_a_q),
        .neg_b_q    (neg_b_q),
        .div_zero_q (div_zero_q),
        .a_q        (a_q),
        .raw        ({work_hi, work_lo}),
        .result     (result)
    );

    // busy lags the state by one edge, so requests are only taken once both agree on idle.
    assign idle        = (state == ST_IDLE) && !busy;
    assign accept_iter = start && idle && is_iterative(op);
    assign accept_mt   = start && idle && ((op == OP_MTHI) || (op == OP_MTLO));

    always_comb begin
        add_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd_q} : 33'd0);
        trial   = {work_hi, work_lo[31]};
        diff    = trial - {1'b0, opnd_q};
        fits    = (trial >= {1'b0, opnd_q});
        if (is_div(op_q)) begin
            next_hi = fits ? diff[31:0] : trial[31:0];
            next_lo = {work_lo[30:0], fits};
        end else begin
            next_hi = add_sum[32:1];
            next_lo = {add_sum[0], work_lo[31:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept_iter) state_next = ST_RUN;
            ST_RUN:    if (count == LAST_ITER) state_next = ST_FINISH;
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            wb_pending <= 1'b0;
            HI         <= 32'd0;
            LO         <= 32'd0;
            count      <= 6'd0;
            op_q       <= 3'd0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            div_zero_q <= 1'b0;
            a_q        <= 32'd0;
            opnd_q     <= 32'd0;
            work_hi    <= 32'd0;
            work_lo    <= 32'd0;
        end else begin
            busy       <= (state != ST_IDLE);
            done       <= wb_pending;
            wb_pending <= (state == ST_FINISH);

            // Multiply shifts the multiplier (B) out of work_lo; divide shifts the dividend (A).
            if (accept_iter) begin
                op_q       <= op;
                neg_a_q    <= neg_a;
                neg_b_q    <= neg_b;
                a_q        <= A;
                div_zero_q <= is_div(op) && (B == 32'd0);
                count      <= 6'd0;
                work_hi    <= 32'd0;
                work_lo    <= is_div(op) ? mag_a : mag_b;
                opnd_q     <= is_div(op) ? mag_b : mag_a;
            end else if (state == ST_RUN) begin
                work_hi <= next_hi;
                work_lo <= next_lo;
                count   <= count + 6'd1;
            end

            if (wb_pending) begin
                HI <= result[63:32];
                LO <= result[31:0];
            end else if (accept_mt) begin
                if (op == OP_MTHI)
                    HI <= A;
                else
                    LO <= A;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized self-checking bench for muldiv_unit against an
// arithmetic reference model of HI/LO results and cycle timing.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [31:0] A     = 32'd0;
    logic [31:0] B     = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    // Reference results straight from integer arithmetic: {HI, LO}.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'd0;
        case (o)
            OP_MULTU: p = {32'd0, a} * {32'd0, b};
            OP_MULT: begin
                q = sa * sb;
                p = q;
            end
            OP_DIVU: p = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            OP_DIV: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: p = 64'd0;
        endcase
        return p;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One iterative op; optionally present an extra start before edge t+injK.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input int injK, input logic [2:0] injOp, input logic [31:0] injVal);
        logic [63:0] r;
        r     = model(o, a, b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        tick();
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        checkOutput("busy_at_t", 32'(busy), 32'd0);
        for (int k = 1; k <= 35; k++) begin
            if (k == injK) begin
                start = 1'b1;
                op    = injOp;
                A     = injVal;
            end
            tick();
            start = 1'b0;
            checkOutput($sformatf("busy_t+%0d", k), 32'(busy), (k < 34) ? 32'd1 : 32'd0);
            checkOutput($sformatf("done_t+%0d", k), 32'(done), (k == 34) ? 32'd1 : 32'd0);
            if (k < 34) begin
                checkOutput($sformatf("hi_hold_t+%0d", k), HI, exp_hi);
                checkOutput($sformatf("lo_hold_t+%0d", k), LO, exp_lo);
            end else begin
                checkOutput($sformatf("hi_op%0d_t+%0d", o, k), HI, r[63:32]);
                checkOutput($sformatf("lo_op%0d_t+%0d", o, k), LO, r[31:0]);
            end
        end
        exp_hi = r[63:32];
        exp_lo = r[31:0];
    endtask

    task automatic moveTo(input logic [2:0] o, input logic [31:0] val);
        start = 1'b1;
        op    = o;
        A     = val;
        tick();
        start = 1'b0;
        if (o == OP_MTHI) exp_hi = val;
        else              exp_lo = val;
        checkOutput("mt_hi", HI, exp_hi);
        checkOutput("mt_lo", LO, exp_lo);
        checkOutput("mt_busy", 32'(busy), 32'd0);
        checkOutput("mt_done", 32'(done), 32'd0);
    endtask

    task automatic noOp(input logic [2:0] o);
        start = 1'b1;
        op    = o;
        A     = $urandom;
        B     = $urandom;
        tick();
        start = 1'b0;
        checkOutput("noop_busy", 32'(busy), 32'd0);
        checkOutput("noop_done", 32'(done), 32'd0);
        checkOutput("noop_hi", HI, exp_hi);
        checkOutput("noop_lo", LO, exp_lo);
        tick();
        checkOutput("noop_busy2", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        $display("[TB] start");
        #12;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_hi", HI, 32'd0);
        checkOutput("rst_lo", LO, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 3'd0, 32'd0);
        applyStimulus(OP_MULT, -32'sd3, 32'd5, 5, OP_MTLO, 32'h0000_1234);
        moveTo(OP_MTLO, 32'h0000_1234);
        applyStimulus(OP_DIV, -32'sd7, 32'd2, 34, OP_MTHI, 32'hDEAD_BEEF);
        applyStimulus(OP_DIVU, 32'd7, 32'd2, 20, OP_MTLO, 32'hCAFE_F00D);
        applyStimulus(OP_DIVU, 32'd5, 32'd0, 0, 3'd0, 32'd0);
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 3'd0, 32'd0);
        applyStimulus(OP_DIV, -32'sd100, 32'd0, 0, 3'd0, 32'd0);
        applyStimulus(OP_DIV, 32'd100, -32'sd7, 0, 3'd0, 32'd0);
        applyStimulus(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0, 3'd0, 32'd0);
        moveTo(OP_MTHI, $urandom);
        noOp(3'b000);
        noOp(3'b111);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       ro = OP_MULT;
                1:       ro = OP_MULTU;
                2:       ro = OP_DIV;
                default: ro = OP_DIVU;
            endcase
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            applyStimulus(ro, ra, rb, 0, 3'd0, 32'd0);
        end

        start = 1'b1;
        op    = OP_MULT;
        A     = $urandom;
        B     = $urandom;
        tick();
        start = 1'b0;
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_hi", HI, 32'd0);
        checkOutput("abort_lo", LO, 32'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            checkOutput($sformatf("post_abort_done_%0d", k), 32'(done), 32'd0);
        end
        checkOutput("post_abort_hi", HI, 32'd0);
        checkOutput("post_abort_lo", LO, 32'd0);

        applyStimulus(OP_MULTU, 32'd12345, 32'd678, 0, 3'd0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
